// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter stage.
package pc_sequencer_pkg;

    localparam int unsigned DefaultPcWidth = 8;

    typedef enum logic [2:0] {
        OpHold     = 3'd0,
        OpInc      = 3'd1,
        OpJump     = 3'd2,
        OpJumpCond = 3'd3,
        OpCall     = 3'd4,
        OpRet      = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO return-address stack; the write pointer is the fill level.
module pc_sequencer_return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = DefaultPcWidth,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                           clk_in,
    input  logic                           reset_n_in,
    input  logic                           push_en_in,
    input  logic                           pop_en_in,
    input  logic [PC_WIDTH-1:0]            data_in,
    output logic [PC_WIDTH-1:0]            data_out,
    output logic [$clog2(STACK_DEPTH):0]   level_out,
    output logic                           full_out,
    output logic                           empty_out
);

    localparam int unsigned IdxWidth   = $clog2(STACK_DEPTH);
    localparam int unsigned LevelWidth = IdxWidth + 1;

    logic [PC_WIDTH-1:0]   entry_q [STACK_DEPTH];
    logic [LevelWidth-1:0] level_q, level_d;
    logic [IdxWidth-1:0]   wr_idx, rd_idx;
    logic                  push_ok, pop_ok;

    assign full_out  = (level_q == LevelWidth'(STACK_DEPTH));
    assign empty_out = (level_q == '0);
    assign push_ok   = push_en_in && !full_out;
    assign pop_ok    = pop_en_in && !empty_out;

    // Depth is a power of two, so the low level bits index the entry array directly.
    assign wr_idx    = level_q[IdxWidth-1:0];
    assign rd_idx    = wr_idx - 1'b1;
    assign data_out  = entry_q[rd_idx];
    assign level_out = level_q;

    always_comb begin
        level_d = level_q;
        if (push_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            entry_q[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, op decode, return stack and sticky stack-fault flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = DefaultPcWidth,
    parameter int unsigned          STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                         clk_in,
    input  logic                         reset_n_in,
    input  logic                         stall_in,
    input  logic [2:0]                   pc_op_in,
    input  logic [PC_WIDTH-1:0]          jump_addr_in,
    input  logic                         cond_in,
    output logic [PC_WIDTH-1:0]          pc_out,
    output logic                         branch_taken_out,
    output logic [$clog2(STACK_DEPTH):0] stack_level_out,
    output logic                         overflow_out,
    output logic                         underflow_out
);

    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, stack_top;
    logic                branch_taken_q, branch_taken_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_en, pop_en, stack_full, stack_empty;
    pc_op_t              op;

    assign op     = pc_op_t'(pc_op_in);
    assign pc_inc = pc_q + 1'b1;

    pc_sequencer_return_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .push_en_in (push_en),
        .pop_en_in  (pop_en),
        .data_in    (pc_inc),
        .data_out   (stack_top),
        .level_out  (stack_level_out),
        .full_out   (stack_full),
        .empty_out  (stack_empty)
    );

    // Stack faults fall back to a sequential step rather than stalling the pipeline.
    always_comb begin
        pc_d           = pc_q;
        branch_taken_d = 1'b0;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        push_en        = 1'b0;
        pop_en         = 1'b0;
        if (!stall_in) begin
            case (op)
                OpInc: pc_d = pc_inc;
                OpJump: begin
                    pc_d           = jump_addr_in;
                    branch_taken_d = 1'b1;
                end
                OpJumpCond: begin
                    if (cond_in) begin
                        pc_d           = jump_addr_in;
                        branch_taken_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                OpCall: begin
                    if (!stack_full) begin
                        push_en        = 1'b1;
                        pc_d           = jump_addr_in;
                        branch_taken_d = 1'b1;
                    end else begin
                        pc_d       = pc_inc;
                        overflow_d = 1'b1;
                    end
                end
                OpRet: begin
                    if (!stack_empty) begin
                        pop_en         = 1'b1;
                        pc_d           = stack_top;
                        branch_taken_d = 1'b1;
                    end else begin
                        pc_d        = pc_inc;
                        underflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pc_q           <= RESET_VECTOR;
            branch_taken_q <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            branch_taken_q <= branch_taken_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign pc_out           = pc_q;
    assign branch_taken_out = branch_taken_q;
    assign overflow_out     = overflow_q;
    assign underflow_out    = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: queue-based reference model, directed plus random ops.
module tb_pc_sequencer;

    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stall;
    logic [2:0] pc_op;
    logic [7:0] jump_addr;
    logic       cond;
    logic [7:0] pc;
    logic       branch_taken;
    logic [2:0] stack_level;
    logic       overflow;
    logic       underflow;

    typedef struct {
        logic [7:0] pc;
        logic       bt;
        logic [2:0] level;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   m_pc;
    int   m_stack[$];
    bit   m_bt, m_ovf, m_unf;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_in           (clk),
        .reset_n_in       (reset_n),
        .stall_in         (stall),
        .pc_op_in         (pc_op),
        .jump_addr_in     (jump_addr),
        .cond_in          (cond),
        .pc_out           (pc),
        .branch_taken_out (branch_taken),
        .stack_level_out  (stack_level),
        .overflow_out     (overflow),
        .underflow_out    (underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_bt  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.delete();
    endtask

    // Drive one op at the falling edge and record what the next rising edge must produce.
    task automatic step(input int op, input int addr, input bit c, input bit st);
        exp_t e;
        @(negedge clk);
        pc_op     = 3'(op);
        jump_addr = 8'(addr);
        cond      = c;
        stall     = st;
        m_bt      = 1'b0;
        if (!st) begin
            case (op)
                1: m_pc = (m_pc + 1) % 256;
                2: begin m_pc = addr; m_bt = 1'b1; end
                3: if (c) begin m_pc = addr; m_bt = 1'b1; end
                   else m_pc = (m_pc + 1) % 256;
                4: if (m_stack.size() < Depth) begin
                       m_stack.push_back((m_pc + 1) % 256);
                       m_pc = addr;
                       m_bt = 1'b1;
                   end else begin
                       m_pc  = (m_pc + 1) % 256;
                       m_ovf = 1'b1;
                   end
                5: if (m_stack.size() > 0) begin
                       m_pc = m_stack.pop_back();
                       m_bt = 1'b1;
                   end else begin
                       m_pc  = (m_pc + 1) % 256;
                       m_unf = 1'b1;
                   end
                default: ;
            endcase
        end
        e.pc    = 8'(m_pc);
        e.bt    = m_bt;
        e.level = 3'(m_stack.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        pc_op   = 3'd0;
        cond    = 1'b0;
        jump_addr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_drain(input string name);
        @(posedge clk);
        #2;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every rising edge the DUT presents a new state; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("branch_taken", branch_taken, e.bt);
                check("stack_level", stack_level, e.level);
                check("overflow", overflow, e.ovf);
                check("underflow", underflow, e.unf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();
        #1;
        check("reset_pc", pc, 8'h00);
        check("reset_bt", branch_taken, 1'b0);
        check("reset_level", stack_level, 3'd0);
        check("reset_flags", {overflow, underflow}, 2'b00);

        repeat (3) step(1, 0, 0, 0);

        step(2, 8'hFF, 0, 0);
        step(1, 0, 0, 0);
        step(3, 8'h40, 0, 0);
        step(3, 8'h40, 1, 0);
        step(0, 8'h12, 1, 0);

        step(2, 8'h10, 0, 0);
        step(4, 8'h20, 0, 0);
        step(4, 8'h30, 0, 0);
        step(5, 0, 0, 0);
        step(5, 0, 0, 0);

        step(4, 8'h60, 0, 0);
        step(4, 8'h61, 0, 0);
        step(4, 8'h62, 0, 0);
        step(4, 8'h50, 0, 0);
        step(4, 8'h70, 0, 0);
        repeat (5) step(5, 0, 0, 0);
        step(6, 8'h21, 0, 0);
        step(7, 8'h22, 1, 0);

        repeat (3) step(2, 8'h80, 0, 1);
        step(2, 8'h80, 0, 0);
        step(4, 8'h40, 0, 1);

        step(4, 8'h40, 0, 0);
        step(4, 8'h32, 0, 0);
        step(1, 0, 0, 0);
        wait_drain("drain_before_async_reset");
        check("pre_reset_pc", pc, 8'h33);
        check("pre_reset_level", stack_level, 3'd2);
        pc_op     = 3'd4;
        jump_addr = 8'hA5;
        reset_n   = 1'b0;
        #1;
        check("async_reset_pc", pc, 8'h00);
        check("async_reset_level", stack_level, 3'd0);
        check("async_reset_bt", branch_taken, 1'b0);
        check("async_reset_flags", {overflow, underflow}, 2'b00);
        @(posedge clk);
        #1;
        check("reset_held_pc", pc, 8'h00);
        check("reset_held_level", stack_level, 3'd0);

        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                wait_drain("drain_mid_random");
                apply_reset();
            end
            step($urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0);
        end
        wait_drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the tiny CPU.
- Consumes the registered branch condition from the status stage (cond) and the decoded PC operation from the decoder.
- Produces the next fetch address.
- Contains a small hardware return stack for call/return, plus sticky fault flags for stack overflow and underflow.

Parameters:
- PC_WIDTH, 8, width of the program counter and of all addresses.
- STACK_DEPTH, 4, number of return-stack entries (power of two, >= 2).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- stall_in  input  1  when 1, freezes PC, stack and flags for this cycle.
- pc_op_in  input  3  operation code, type pc_op_t: HOLD, INC, JUMP, JUMP_COND, CALL, RET.
- jump_addr_in  input  PC_WIDTH  absolute target for JUMP, JUMP_COND and CALL.
- cond_in  input  1  branch condition from the status stage, sampled in the same cycle as pc_op_in.
- pc_out  output  PC_WIDTH  current fetch address (registered).
- branch_taken_out  output  1  registered; 1 for one cycle after any non-sequential PC update.
- stack_level_out  output  $clog2(STACK_DEPTH)+1  number of valid return-stack entries.
- overflow_out  output  1  sticky; set by a CALL while the stack is full.
- underflow_out  output  1  sticky; set by a RET while the stack is empty.

Behaviour:
- Reset (async assert, sync release): pc_out=RESET_VECTOR, branch_taken_out=0, stack_level_out=0, overflow_out=0, underflow_out=0. Stack contents are undefined.
- Latency: one cycle. pc_out reflects the op sampled on the previous rising edge.
- stall_in=1: all registers hold, branch_taken_out is forced to 0, pc_op_in is ignored. Stall has priority over every op.
- HOLD: PC unchanged, branch_taken_out=0.
- INC: PC <= PC+1, wrapping modulo 2^PC_WIDTH (max -> 0), branch_taken_out=0.
- JUMP: PC <= jump_addr_in, branch_taken_out=1.
- JUMP_COND:
  - cond_in=1: behaves as JUMP.
  - cond_in=0: behaves as INC (branch_taken_out=0).
- CALL, stack not full:
  - push PC+1 (wrapped), PC <= jump_addr_in, level+1, branch_taken_out=1.
- CALL, stack full:
  - no push, no jump; PC <= PC+1, overflow_out <= 1, branch_taken_out=0.
- RET, stack not empty:
  - PC <= top entry, level-1, branch_taken_out=1.
- RET, stack empty:
  - PC <= PC+1, underflow_out <= 1, branch_taken_out=0.
- Sticky flags are cleared only by reset. They never block subsequent ops.
- Undefined pc_op_in encodings (6, 7): treated as HOLD.
- Stack is LIFO with a write pointer = level.
  - push writes entry[level].
  - pop reads entry[level-1].
  - No simultaneous push and pop is possible, since exactly one op is active per cycle.
- Reset asserted mid-sequence (e.g. during a CALL cycle): reset wins immediately and asynchronously; the pending op is discarded.

Decomposition:
- common_pkg additions:
  - pc_op_t enum (HOLD=3'd0, INC=3'd1, JUMP=3'd2, JUMP_COND=3'd3, CALL=3'd4, RET=3'd5).
  - Default PC_WIDTH constant.
- Sub-module return_stack:
  - Parameters PC_WIDTH and STACK_DEPTH.
  - Inputs: clk_in, reset_n_in, push_en_in, pop_en_in, data_in.
  - Outputs: data_out, level_out, full_out, empty_out.
  - Enforces no push when full and no pop when empty.
- pc_sequencer holds the PC register, op decode, fault flags and branch_taken_out.

Test Plan:
- Reset then INC x3 -> pc_out 0,1,2,3; branch_taken_out stays 0; flags 0.
- PC=0xFF, INC -> pc_out=0x00. JUMP_COND addr=0x40: with cond_in=0 -> pc_out=0x01; with cond_in=1 -> pc_out=0x40 and branch_taken_out=1 for one cycle.
- Nested calls from PC=0x10: CALL 0x20, CALL 0x30, then RET, RET -> pc_out 0x20, 0x30, 0x21, 0x11; stack_level_out 1, 2, 1, 0.
- Four CALLs fill the stack (level=4), fifth CALL at PC=0x50 -> pc_out=0x51, overflow_out=1, level stays 4. Then four RETs unwind in LIFO order, and a fifth RET sets underflow_out=1 with PC+1.
- stall_in=1 for 3 cycles while pc_op_in=JUMP 0x80 -> pc_out unchanged and branch_taken_out=0 throughout. Releasing the stall with the op still JUMP -> pc_out=0x80 on the next edge.
- Assert reset_n_in low between clock edges after PC=0x33 and level=2 -> pc_out=RESET_VECTOR and level=0 immediately, without waiting for a clock edge; flags cleared.
